// File: rtl/bucket_histogram.sv
// bucket_histogram: per-window occurrence counter for 3-bit bucket codes.
// Codes 1..4 are counted into buckets 0..3 (saturating); codes 0/5/6/7 are
// accepted but only raise a sticky window error flag. After WIN_LEN accepted
// samples the four counts are streamed out over valid/ready, one bucket per
// beat, and the block then starts a fresh window.
module bucket_histogram #(
   parameter int CNT_W   = 8,
   parameter int WIN_LEN = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [2:0]       in_code,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_bucket,
   output logic [CNT_W-1:0] out_count,
   output logic             out_last,
   output logic             out_err
);

   // Sample counter holds 0..WIN_LEN.
   localparam int SMP_W = $clog2(WIN_LEN + 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {
      ACCUM = 1'b0,
      DUMP  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [SMP_W-1:0] smp_cnt;
   logic [SMP_W-1:0] smp_cnt_next;
   logic [1:0]       beat;
   logic [1:0]       beat_next;
   logic             err_flag;
   logic             err_next;

   logic             accept;
   logic             code_legal;
   logic [1:0]       code_idx;
   logic             handshake;
   logic             win_done;

   // All four bucket counters packed side by side; bucket b occupies
   // bits [b*CNT_W +: CNT_W].
   logic [4*CNT_W-1:0] count_flat;
   logic [CNT_W-1:0]   beat_count;

   // Decode the incoming sample and the output handshake.
   always_comb begin
      accept     = (state == ACCUM) && in_valid;
      code_legal = (in_code >= 3'd1) && (in_code <= 3'd4);
      // Codes 1..4 map to 0..3; code 4 (3'b100) wraps 2'b00 - 1 to 2'b11.
      code_idx   = in_code[1:0] - 2'd1;
      handshake  = (state == DUMP) && out_ready;
      win_done   = handshake && (beat == 2'd3);
   end

   // Next-state logic for the window FSM, sample counter, beat index and error flag.
   always_comb begin
      state_next   = state;
      smp_cnt_next = smp_cnt;
      beat_next    = beat;
      err_next     = err_flag;
      unique case (state)
         ACCUM: begin
            if (accept) begin
               smp_cnt_next = smp_cnt + 1'b1;
               if (!code_legal) begin
                  err_next = 1'b1;
               end
               // The sample that completes the window is still counted above.
               if ((smp_cnt + 1'b1) == SMP_LAST) begin
                  state_next = DUMP;
               end
            end
         end
         DUMP: begin
            if (handshake) begin
               if (beat == 2'd3) begin
                  state_next   = ACCUM;
                  beat_next    = 2'd0;
                  smp_cnt_next = '0;
                  err_next     = 1'b0;
               end else begin
                  beat_next = beat + 2'd1;
               end
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // Control state registers; reset abandons any window in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ACCUM;
         smp_cnt  <= '0;
         beat     <= 2'd0;
         err_flag <= 1'b0;
      end else begin
         state    <= state_next;
         smp_cnt  <= smp_cnt_next;
         beat     <= beat_next;
         err_flag <= err_next;
      end
   end

   // One saturating counter per bucket, cleared when the last beat is taken.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bucket
         localparam logic [1:0] IDX = 2'(gi);
         logic [CNT_W-1:0] cnt;
         logic             hit;

         // A legal accepted sample for this bucket.
         always_comb begin
            hit = accept && code_legal && (code_idx == IDX);
         end

         // Count hits, holding at full scale instead of wrapping.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
            end else if (win_done) begin
               cnt <= '0;
            end else if (hit && (cnt != CNT_MAX)) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign count_flat[gi*CNT_W +: CNT_W] = cnt;
      end
   endgenerate

   // Select the counter for the current beat.
   always_comb begin
      beat_count = count_flat[beat*CNT_W +: CNT_W];
   end

   // Outputs depend only on registered state; the count is blanked outside a dump.
   always_comb begin
      in_ready   = (state == ACCUM);
      out_valid  = (state == DUMP);
      out_bucket = (state == DUMP) ? beat : 2'd0;
      out_count  = (state == DUMP) ? beat_count : '0;
      out_last   = (state == DUMP) && (beat == 2'd3);
      out_err    = (state == DUMP) && (beat == 2'd3) && err_flag;
   end

endmodule

// File: tb/tb_bucket_histogram.sv
// Directed bench for bucket_histogram: three instances cover the default
// configuration (8/16), a narrow saturating one (3/12) and a short window (8/4).
// Only the instance picked by sel sees in_valid; its outputs are muxed out.
module tb_bucket_histogram;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] in_code;
   logic       out_ready;
   logic [1:0] sel;

   logic       in_valid_a, in_valid_b, in_valid_c;
   logic       in_ready_a, in_ready_b, in_ready_c;
   logic       out_valid_a, out_valid_b, out_valid_c;
   logic [1:0] out_bucket_a, out_bucket_b, out_bucket_c;
   logic [7:0] out_count_a, out_count_c;
   logic [2:0] out_count_b;
   logic       out_last_a, out_last_b, out_last_c;
   logic       out_err_a, out_err_b, out_err_c;

   logic       in_ready_s, out_valid_s, out_last_s, out_err_s;
   logic [1:0] out_bucket_s;
   logic [7:0] out_count_s;

   int n_vec  = 0;
   int n_miss = 0;
   int hs_cnt = 0;

   assign in_valid_a = in_valid && (sel == 2'd0);
   assign in_valid_b = in_valid && (sel == 2'd1);
   assign in_valid_c = in_valid && (sel == 2'd2);

   bucket_histogram #(.CNT_W(8), .WIN_LEN(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_code(in_code),
      .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_bucket(out_bucket_a), .out_count(out_count_a),
      .out_last(out_last_a), .out_err(out_err_a));

   bucket_histogram #(.CNT_W(3), .WIN_LEN(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_code(in_code),
      .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_bucket(out_bucket_b), .out_count(out_count_b),
      .out_last(out_last_b), .out_err(out_err_b));

   bucket_histogram #(.CNT_W(8), .WIN_LEN(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_code(in_code),
      .in_ready(in_ready_c), .out_valid(out_valid_c), .out_ready(out_ready),
      .out_bucket(out_bucket_c), .out_count(out_count_c),
      .out_last(out_last_c), .out_err(out_err_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Route the selected instance's outputs to the common observation signals.
   always_comb begin
      case (sel)
         2'd1: begin
            in_ready_s = in_ready_b; out_valid_s = out_valid_b; out_bucket_s = out_bucket_b;
            out_count_s = {5'd0, out_count_b}; out_last_s = out_last_b; out_err_s = out_err_b;
         end
         2'd2: begin
            in_ready_s = in_ready_c; out_valid_s = out_valid_c; out_bucket_s = out_bucket_c;
            out_count_s = out_count_c; out_last_s = out_last_c; out_err_s = out_err_c;
         end
         default: begin
            in_ready_s = in_ready_a; out_valid_s = out_valid_a; out_bucket_s = out_bucket_a;
            out_count_s = out_count_a; out_last_s = out_last_a; out_err_s = out_err_a;
         end
      endcase
   end

   // Count output handshakes on the selected instance.
   always @(posedge clk) begin
      if (out_valid_s && out_ready) hs_cnt <= hs_cnt + 1;
   end

   typedef struct {
      logic [1:0] sel;
      int         n;
      logic [2:0] codes [16];
      int         exp_cnt [4];
      bit         exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at the falling edge of beat 0 with out_ready=1; walks all four beats.
   task automatic check_dump(input string tag, input int e0, input int e1,
                             input int e2, input int e3, input bit ee);
      int ec [4];
      ec = '{e0, e1, e2, e3};
      for (int b = 0; b < 4; b++) begin
         check($sformatf("%s beat%0d out_valid", tag, b), 32'(out_valid_s), 32'd1);
         check($sformatf("%s beat%0d in_ready", tag, b), 32'(in_ready_s), 32'd0);
         check($sformatf("%s beat%0d out_bucket", tag, b), 32'(out_bucket_s), 32'(b));
         check($sformatf("%s beat%0d out_count", tag, b), 32'(out_count_s), 32'(ec[b]));
         check($sformatf("%s beat%0d out_last", tag, b), 32'(out_last_s), 32'(b == 3));
         check($sformatf("%s beat%0d out_err", tag, b), 32'(out_err_s), 32'((b == 3) && ee));
         $display("%s beat %0d: bucket=%0d count=%0d last=%0d err=%0d",
                  tag, b, out_bucket_s, out_count_s, out_last_s, out_err_s);
         @(negedge clk);
      end
      check($sformatf("%s after dump in_ready", tag), 32'(in_ready_s), 32'd1);
      check($sformatf("%s after dump out_valid", tag), 32'(out_valid_s), 32'd0);
   endtask

   // Stream a window back-to-back, then check the full dump.
   task automatic run_window(input string tag, input vec_t v);
      sel       = v.sel;
      out_ready = 1'b1;
      for (int i = 0; i < v.n; i++) begin
         @(negedge clk);
         check($sformatf("%s sample%0d in_ready", tag, i), 32'(in_ready_s), 32'd1);
         in_valid = 1'b1;
         in_code  = v.codes[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      check_dump(tag, v.exp_cnt[0], v.exp_cnt[1], v.exp_cnt[2], v.exp_cnt[3], v.exp_err);
   endtask

   initial begin
      vec_t v;
      int   hs_base;

      vecs[0] = '{sel: 2'd0, n: 16,
                  codes: '{3'd1,3'd1,3'd2,3'd3,3'd4,3'd4,3'd4,3'd1,3'd2,3'd2,3'd3,3'd3,3'd4,3'd1,3'd1,3'd2},
                  exp_cnt: '{5,4,3,4}, exp_err: 1'b0};
      vecs[1] = '{sel: 2'd0, n: 16,
                  codes: '{3'd0,3'd1,3'd2,3'd3,3'd4,3'd4,3'd4,3'd1,3'd2,3'd2,3'd3,3'd3,3'd4,3'd1,3'd1,3'd2},
                  exp_cnt: '{4,4,3,4}, exp_err: 1'b1};
      vecs[2] = vecs[0];
      vecs[3] = '{sel: 2'd1, n: 12,
                  codes: '{3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd2,3'd0,3'd0,3'd0,3'd0},
                  exp_cnt: '{0,7,0,0}, exp_err: 1'b0};
      vecs[4] = '{sel: 2'd1, n: 12,
                  codes: '{3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd1,3'd3,3'd3,3'd4,3'd0,3'd0,3'd0,3'd0,3'd0},
                  exp_cnt: '{7,0,2,1}, exp_err: 1'b1};
      vecs[5] = '{sel: 2'd2, n: 4,
                  codes: '{3'd1,3'd2,3'd3,3'd4,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
                  exp_cnt: '{1,1,1,1}, exp_err: 1'b0};
      vecs[6] = '{sel: 2'd2, n: 4,
                  codes: '{3'd5,3'd6,3'd7,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
                  exp_cnt: '{1,0,0,0}, exp_err: 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = 3'd0;
      out_ready = 1'b1;
      sel       = 2'd0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset in_ready", 32'(in_ready_s), 32'd1);
      check("reset out_valid", 32'(out_valid_s), 32'd0);
      check("reset out_bucket", 32'(out_bucket_s), 32'd0);
      check("reset out_count", 32'(out_count_s), 32'd0);
      check("reset out_last", 32'(out_last_s), 32'd0);
      check("reset out_err", 32'(out_err_s), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of full windows.
      for (int k = 0; k < 7; k++) begin
         run_window($sformatf("vec%0d", k), vecs[k]);
      end

      // Backpressure: stall 5 cycles on beat 1 while in_valid is driven.
      sel       = 2'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_code  = vecs[0].codes[i];
      end
      @(negedge clk);
      hs_base = hs_cnt;
      in_code = 3'd1;
      check("bp beat0 out_count", 32'(out_count_s), 32'd5);
      @(negedge clk);
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         check($sformatf("bp stall%0d out_valid", s), 32'(out_valid_s), 32'd1);
         check($sformatf("bp stall%0d out_bucket", s), 32'(out_bucket_s), 32'd1);
         check($sformatf("bp stall%0d out_count", s), 32'(out_count_s), 32'd4);
         check($sformatf("bp stall%0d out_last", s), 32'(out_last_s), 32'd0);
         $display("bp stall %0d: bucket=%0d count=%0d", s, out_bucket_s, out_count_s);
         @(negedge clk);
      end
      check("bp held out_bucket", 32'(out_bucket_s), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp beat2 out_bucket", 32'(out_bucket_s), 32'd2);
      check("bp beat2 out_count", 32'(out_count_s), 32'd3);
      @(negedge clk);
      check("bp beat3 out_count", 32'(out_count_s), 32'd4);
      check("bp beat3 out_last", 32'(out_last_s), 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      check("bp after in_ready", 32'(in_ready_s), 32'd1);
      check("bp handshakes", 32'(hs_cnt - hs_base), 32'd4);
      v = vecs[0];
      v.codes   = '{3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4};
      v.exp_cnt = '{0,0,0,16};
      run_window("bp next", v);

      // Toggled in_valid with code 3 on the WIN_LEN=4 instance.
      sel       = 2'd2;
      out_ready = 1'b1;
      in_code   = 3'd3;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("toggle cycle%0d out_valid", k), 32'(out_valid_s), 32'(k == 8));
         in_valid = (k % 2 == 1);
      end
      check_dump("toggle", 0, 0, 4, 0, 1'b0);

      // Reset during beat 2 of a dump, then a fresh window.
      sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_code  = 3'd1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst beat2 out_bucket", 32'(out_bucket_s), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("rst in_ready", 32'(in_ready_s), 32'd1);
      check("rst out_valid", 32'(out_valid_s), 32'd0);
      check("rst out_bucket", 32'(out_bucket_s), 32'd0);
      check("rst out_count", 32'(out_count_s), 32'd0);
      check("rst out_last", 32'(out_last_s), 32'd0);
      check("rst out_err", 32'(out_err_s), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      v = vecs[5];
      v.codes   = '{3'd4,3'd4,3'd4,3'd4,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0};
      v.exp_cnt = '{0,0,0,4};
      v.exp_err = 1'b0;
      run_window("post-rst", v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bucket_histogram.md
# bucket_histogram

Downstream consumer of the 3-bit bucket-code stage (codes 1..4 = data quartiles 0-3, 4-7, 8-11, 12-15). It accepts one bucket code per valid cycle, accumulates per-bucket occurrence counts over a fixed window of `WIN_LEN` accepted samples, then streams the four counts out over a valid/ready interface before starting the next window. Illegal codes (0, 5, 6, 7) are flagged, not counted.

## Interface
- `CNT_W`, default 8: width of each per-bucket counter and of `out_count`.
- `WIN_LEN`, default 16: accepted samples per window; legal range 1..65535.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_code` holds a sample this cycle.
- `in_code`  in  3  bucket code; 1..4 legal, 0/5/6/7 illegal.
- `in_ready`  out  1  block accepts a sample this cycle.
- `out_valid`  out  1  `out_bucket`/`out_count`/`out_last`/`out_err` are valid.
- `out_ready`  in  1  sink accepts the current beat.
- `out_bucket`  out  2  bucket index 0..3, i.e. code minus 1.
- `out_count`  out  CNT_W  count for `out_bucket` in the finished window.
- `out_last`  out  1  high on the bucket-3 beat.
- `out_err`  out  1  on the last beat only: at least one illegal code was accepted in the window; 0 on other beats.

## Operation
- Two states: ACCUM and DUMP. Reset enters ACCUM with all counters, the sample counter, the beat index and the error flag at 0.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - Accept occurs when `in_valid`=1. A legal code `c` increments `count[c-1]`, saturating at 2^CNT_W-1.
  - An illegal code sets the sticky window error flag and increments no bucket.
  - Both legal and illegal codes increment the sample counter.
  - An accept that brings the sample counter to `WIN_LEN` moves the block to DUMP. That final sample is included in the counts.
- DUMP:
  - `in_ready`=0; `in_valid` is ignored.
  - `out_valid`=1 with beat index `b`, starting at 0: `out_bucket`=b, `out_count`=count[b], `out_last`=(b==3), `out_err`=(b==3) & error flag.
  - A handshake (`out_valid` & `out_ready`) advances `b`. Outputs hold stable while `out_ready`=0.
  - A handshake on beat 3 clears all counters, the sample counter, `b` and the error flag, and returns to ACCUM.
- Every output is a function of registered state only; there is no combinational path from any input to any output.
- Asynchronous reset at any time, including mid-window or mid-dump, discards the window and returns to the reset state. No partial dump is emitted.
- Reset values: `in_ready`=1, `out_valid`=0, `out_bucket`=0, `out_count`=0, `out_last`=0, `out_err`=0.
- Sample counter width is clog2(WIN_LEN+1).

## Timing
- The accept at edge N updates its count at edge N. The count is visible internally in cycle N+1.
- The WIN_LEN-th accept at edge N gives `in_ready`=0 and `out_valid`=1 in cycle N+1.
- With `out_ready` held at 1, the dump takes exactly 4 cycles, N+1..N+4. `in_ready`=1 again in cycle N+5.
- Minimum window period is WIN_LEN + 4 cycles.
- When `WIN_LEN`=1, every accept is immediately followed by a 4-beat dump.

## Test plan
- WIN_LEN=16, codes 1,1,2,3,4,4,4,1,2,2,3,3,4,1,1,2 streamed back-to-back, `out_ready`=1.
  - Beats (bucket,count): (0,5), (1,4), (2,3), (3,4).
  - `out_last` high on beat 3 only; `out_err`=0; `in_ready` low exactly 4 cycles.
- Same window with one code 1 replaced by 0 -> bucket 0 count 4, `out_err`=1 on the last beat. The next window with all-legal codes shows `out_err`=0.
- CNT_W=3, WIN_LEN=12, twelve code-2 samples -> bucket 1 count 7 (saturated), others 0.
- Backpressure: `out_ready` low for 5 cycles at beat 1, then high -> beat 1 outputs held constant through the stall; 4 handshakes total; `in_valid` during the dump is not counted in the next window.
- `in_valid` toggled 1,0,1,0... with code 3, WIN_LEN=4 -> dump starts the cycle after the 4th accept, cycle 8 from first valid; bucket 2 count 4.
- Assert `rst_n` low during beat 2 of a dump -> outputs go to reset values immediately. After release, a fresh window of four code-4 samples (WIN_LEN=4) gives counts 0,0,0,4.
